// File: rtl/pwm_pkg.sv
// pwm_pkg: shared widths, constants and register map for the PWM peripheral and its SPI register block
package pwm_pkg;
  localparam int PWM_W = 8;
  localparam logic [PWM_W-1:0] PWM_FULL = 8'hFF;
  localparam int NUM_PINS = 16;
  localparam logic [6:0] ADDR_EN_OUT_7_0 = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_15_8 = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_7_0 = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_15_8 = 7'h03;
  localparam logic [6:0] ADDR_PWM_DUTY = 7'h04;
endpackage

// File: rtl/pwm_peripheral_if.sv
// pwm_peripheral_if: configuration registers in, pin drive and period strobe out
interface pwm_peripheral_if;
  import pwm_pkg::*;
  logic [7:0] en_reg_out_7_0;
  logic [7:0] en_reg_out_15_8;
  logic [7:0] en_reg_pwm_7_0;
  logic [7:0] en_reg_pwm_15_8;
  logic [PWM_W-1:0] pwm_duty_cycle;
  logic [NUM_PINS-1:0] out;
  logic period_start;
  modport master (
    output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle,
    input out, period_start
  );
  modport slave (
    input en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle,
    output out, period_start
  );
endinterface

// File: rtl/pwm_prescaler.sv
// pwm_prescaler: divides clk down to a one-cycle tick every PRESCALE cycles
module pwm_prescaler #(
  parameter int PRESCALE = 13,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  logic [CNT_W-1:0] pre_cnt;
  assign tick = pre_cnt == CNT_W'(PRESCALE - 1);
  always_ff @(posedge clk)
    if (!rst_n) pre_cnt <= '0;
    else pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
endmodule

// File: rtl/pwm_peripheral.sv
// pwm_peripheral: drives 16 pins low, high or with a shared glitch-free 8-bit PWM waveform
module pwm_peripheral
  import pwm_pkg::*;
#(
  parameter int PRESCALE = 13,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst_n,
  pwm_peripheral_if.slave bus
);
  logic tick, wrap, pwm_lvl;
  logic [PWM_W-1:0] pwm_cnt, duty_shadow;
  logic [NUM_PINS-1:0] en_out, en_pwm;
  assign en_out = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
  assign en_pwm = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};
  pwm_prescaler #(.PRESCALE(PRESCALE), .CNT_W(CNT_W)) u_pre (.clk(clk), .rst_n(rst_n), .tick(tick));
  assign wrap = tick && pwm_cnt == PWM_FULL;
  // full scale is forced high so 0xFF never shows a one-tick low at the wrap
  assign pwm_lvl = (duty_shadow == PWM_FULL) | (pwm_cnt < duty_shadow);
  always_ff @(posedge clk)
    if (!rst_n) begin
      pwm_cnt <= '0;
      duty_shadow <= '0;
      bus.out <= '0;
      bus.period_start <= 1'b0;
    end else begin
      pwm_cnt <= tick ? pwm_cnt + 1'b1 : pwm_cnt;
      duty_shadow <= wrap ? bus.pwm_duty_cycle : duty_shadow;
      bus.out <= en_out & (~en_pwm | {NUM_PINS{pwm_lvl}});
      bus.period_start <= wrap;
    end
endmodule

// File: tb/tb_pwm_peripheral.sv
// tb_pwm_peripheral: directed checks of gating, duty extremes, shadowing and reset for two prescale settings
module tb_pwm_peripheral;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sel = 1'b0;
  logic ps, o0;
  int n_cmp = 0;
  int n_bad = 0;
  int h;
  always #5 clk = ~clk;
  pwm_peripheral_if i2 ();
  pwm_peripheral_if i1 ();
  pwm_peripheral #(.PRESCALE(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(i2.slave));
  pwm_peripheral #(.PRESCALE(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(i1.slave));
  assign ps = sel ? i1.period_start : i2.period_start;
  assign o0 = sel ? i1.out[0] : i2.out[0];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ps(input string tag);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (ps !== 1'b1 && k < 2000);
    chk(tag, 32'(ps === 1'b1), 32'd1);
  endtask

  // samples out[0] on the next n falling edges; optionally rewrites the duty at sample wr_at
  task automatic measure(input int n, input int wr_at, input logic [7:0] wr_val, output int highs);
    highs = 0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (k == wr_at) i2.pwm_duty_cycle = wr_val;
      highs += (o0 === 1'b1) ? 1 : 0;
    end
  endtask

  task automatic set_en(input logic [15:0] eo, input logic [15:0] ep);
    {i2.en_reg_out_15_8, i2.en_reg_out_7_0} = eo;
    {i2.en_reg_pwm_15_8, i2.en_reg_pwm_7_0} = ep;
  endtask

  initial begin
    set_en(16'hFFFF, 16'h0000);
    i2.pwm_duty_cycle = 8'h00;
    {i1.en_reg_out_15_8, i1.en_reg_out_7_0} = 16'h0001;
    {i1.en_reg_pwm_15_8, i1.en_reg_pwm_7_0} = 16'h0001;
    i1.pwm_duty_cycle = 8'h01;
    repeat (2) @(negedge clk);
    chk("reset_out", 32'(i2.out), 32'h0000);
    chk("reset_ps", 32'(i2.period_start), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("release_out", 32'(i2.out), 32'hFFFF);
    set_en(16'h00F0, 16'h0000);
    @(negedge clk);
    chk("en_gate", 32'(i2.out), 32'h00F0);
    set_en(16'h0001, 16'h0001);
    i2.pwm_duty_cycle = 8'h80;
    wait_ps("half_ps0");
    measure(512, 0, 8'h00, h);
    chk("half_hi_p1", 32'(h), 32'd256);
    chk("half_ps_p1", 32'(ps), 32'h1);
    measure(512, 0, 8'h00, h);
    chk("half_hi_p2", 32'(h), 32'd256);
    chk("half_ps_p2", 32'(ps), 32'h1);
    i2.pwm_duty_cycle = 8'h00;
    wait_ps("zero_ps");
    measure(1024, 0, 8'h00, h);
    chk("zero_hi", 32'(h), 32'd0);
    i2.pwm_duty_cycle = 8'hFF;
    wait_ps("full_ps");
    measure(1024, 0, 8'h00, h);
    chk("full_hi", 32'(h), 32'd1024);
    chk("full_ps_end", 32'(ps), 32'h1);
    i2.pwm_duty_cycle = 8'h40;
    wait_ps("mid_ps");
    measure(512, 32, 8'hC0, h);
    chk("mid_cur", 32'(h), 32'd128);
    chk("mid_ps_next", 32'(ps), 32'h1);
    measure(512, 0, 8'h00, h);
    chk("mid_next", 32'(h), 32'd384);
    i2.pwm_duty_cycle = 8'hFF;
    wait_ps("rst_ps");
    measure(254, 0, 8'h00, h);
    chk("rst_pre_hi", 32'(h), 32'd254);
    chk("rst_pre_cnt", 32'(u2.pwm_cnt), 32'h7F);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_out", 32'(i2.out), 32'h0000);
    chk("rst_cnt", 32'(u2.pwm_cnt), 32'h00);
    chk("rst_pre", 32'(u2.u_pre.pre_cnt), 32'h0);
    chk("rst_shadow", 32'(u2.duty_shadow), 32'h00);
    chk("rst_ps", 32'(i2.period_start), 32'h0);
    rst_n = 1'b1;
    measure(512, 0, 8'h00, h);
    chk("post_rst_hi", 32'(h), 32'd0);
    chk("post_rst_ps", 32'(ps), 32'h1);
    measure(512, 0, 8'h00, h);
    chk("post_rst_full", 32'(h), 32'd512);
    sel = 1'b1;
    wait_ps("p1_ps");
    @(negedge clk);
    chk("p1_first", 32'(o0), 32'h1);
    measure(255, 0, 8'h00, h);
    chk("p1_rest", 32'(h), 32'd0);
    chk("p1_ps", 32'(ps), 32'h1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pwm_peripheral.md
Name: pwm_peripheral

Overview:
- Downstream consumer of the SPI register block; takes its five configuration registers and drives 16 output pins.
- Each pin is either forced low, driven statically high, or driven with a shared 8-bit PWM waveform.
- The PWM waveform is glitch-free: the duty cycle is resampled only at a period boundary.
- Sits between the SPI register bank and the chip output pads (uo_out / uio_out mapping is done at top level).

Parameters:
- PRESCALE, 13, clk cycles per PWM tick; legal range 1..65535. 10 MHz / (13*256) gives about 3 kHz.
- CNT_W, 16, width of the prescaler counter; must satisfy 2**CNT_W > PRESCALE-1.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- en_reg_out_7_0  input  8  output enable, pins 7..0.
- en_reg_out_15_8  input  8  output enable, pins 15..8.
- en_reg_pwm_7_0  input  8  PWM select, pins 7..0.
- en_reg_pwm_15_8  input  8  PWM select, pins 15..8.
- pwm_duty_cycle  input  8  duty value; 0x00 means 0%, 0xFF means 100%.
- out  output  16  registered pin drive.
- period_start  output  1  one-clk pulse on the first cycle of each PWM period.

Behaviour:
- Reset (rst_n low at a clk edge): pre_cnt=0, pwm_cnt=0, duty_shadow=0x00, out=16'h0000, period_start=0.
  - Reset mid-period aborts the period immediately; no partial-period completion.
- Prescaler:
  - tick = (pre_cnt == PRESCALE-1).
  - On tick, pre_cnt goes to 0; otherwise pre_cnt+1.
  - With PRESCALE=1, tick is asserted every cycle.
- PWM counter, 8-bit, range 0..255:
  - Increments on tick and wraps 255 to 0 (period of 256 ticks).
  - Holds when there is no tick.
- Duty shadow:
  - wrap = tick && pwm_cnt==255.
  - On wrap, duty_shadow <= pwm_duty_cycle.
  - A duty change mid-period has no effect until the next period.
  - Multiple changes within one period: only the value present on the wrap cycle is taken.
  - After reset, the first period runs with duty 0, so PWM outputs stay low for the first 256 ticks.
- PWM level:
  - pwm_lvl = (duty_shadow==8'hFF) | (pwm_cnt < duty_shadow), evaluated combinationally.
  - 0x00 gives constant low.
  - 0xFF gives constant high; this is a special case, not 255/256.
  - Any other value N gives high for N ticks out of 256.
- Per-pin select, registered each clk:
  - out[i] <= en_out[i] ? (en_pwm[i] ? pwm_lvl : 1'b1) : 1'b0.
  - en_out / en_pwm are the concatenated {_15_8,_7_0} registers.
  - An enable with its PWM select cleared drives high; a cleared enable drives low regardless of the PWM select.
- Latency:
  - A change on the enable inputs reaches out one clk later.
  - out lags pwm_cnt by one clk.
- period_start <= wrap, so it is high for exactly one clk, aligned with pwm_cnt==0 and the new duty_shadow.
- Inputs are quasi-static, already in the clk domain; no synchronisers.
- No handshake with the SPI block; its registers are sampled continuously.

Decomposition:
- Shared package pwm_pkg:
  - PWM_W=8.
  - PWM_FULL=8'hFF.
  - NUM_PINS=16.
  - Register address constants 0x00..0x04, shared with the SPI register block.
- One sub-module, pwm_prescaler (parameter PRESCALE): ports clk, rst_n, tick.
- Counter, shadow and pin mux stay in pwm_peripheral.

Test Plan:
- Reset/enable gating. Setup: PRESCALE=2, en_out=16'hFFFF, en_pwm=16'h0000, then rst_n low for 2 clk. Required:
  - out=16'h0000 while in reset.
  - out=16'hFFFF one clk after release.
  - Setting en_out=16'h00F0 gives out=16'h00F0 one clk later.
- Half duty. Setup: PRESCALE=2, en_out=en_pwm=16'h0001, duty=0x80. Required, from the second period onward:
  - out[0] high 256 clk, low 256 clk per 512-clk period.
  - period_start pulses every 512 clk.
- Extremes. Same setup with duty=0x00, then duty=0xFF. Required:
  - duty=0x00: out[0] constantly low over two full periods.
  - duty=0xFF: out[0] constantly high over two full periods, with no one-tick low glitch at the wrap.
- Mid-period update. Duty 0x40 is running; write 0xC0 at pwm_cnt=0x10. Required:
  - Current period still gives 64 high ticks.
  - The next period, starting with the period_start pulse, gives 192 high ticks.
- PRESCALE=1 with duty=0x01. Required:
  - out[0] high exactly 1 clk per 256-clk period.
- Reset mid-period. Assert rst_n low at pwm_cnt=0x7F with duty 0xFF active. Required:
  - out=0 and counters=0 on the next clk.
  - The first post-reset period is all low (duty_shadow=0).
